// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, NOP encoding and ALU operation codes.
// Used by the decoder and by every pipeline register that carries the control bundle.
package pipe_pkg;

   localparam int CTRL_W       = 20;
   localparam int BUBBLE_CNT_W = 16;

   // Bit positions inside the packed control bundle, MSB to LSB.
   localparam int CTRL_REGDST_LSB   = 18;
   localparam int CTRL_ALUOP_LSB    = 13;
   localparam int CTRL_ALUSRCA_LSB  = 11;
   localparam int CTRL_ALUSRCB_LSB  = 9;
   localparam int CTRL_EXTOP_LSB    = 7;
   localparam int CTRL_MEMREAD_BIT  = 6;
   localparam int CTRL_MEMWRITE_BIT = 5;
   localparam int CTRL_REGWRITE_BIT = 4;
   localparam int CTRL_MEMTOREG_LSB = 2;
   localparam int CTRL_JUMP_LSB     = 0;

   typedef struct packed {
      logic [1:0] reg_dst;
      logic [4:0] alu_op;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] ext_op;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic [1:0] jump;
   } ctrl_t;

   localparam logic [31:0]       NOP_INSTR = 32'h0000_0000;
   localparam logic [CTRL_W-1:0] CTRL_NOP  = '0;

   typedef enum logic [4:0] {
      ALU_NOP  = 5'd0,
      ALU_ADD  = 5'd1,
      ALU_SUB  = 5'd2,
      ALU_AND  = 5'd3,
      ALU_OR   = 5'd4,
      ALU_XOR  = 5'd5,
      ALU_NOR  = 5'd6,
      ALU_SLT  = 5'd7,
      ALU_SLTU = 5'd8,
      ALU_SLL  = 5'd9,
      ALU_SRL  = 5'd10,
      ALU_SRA  = 5'd11,
      ALU_LUI  = 5'd12
   } alu_op_e;

   function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEMREAD_BIT];
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: raises stall when the load in EX writes a register the ID instruction reads.
// Purely combinational; register $0 never creates a dependency.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       hold,
   input  logic       rst,
   output logic       stall
);

   logic rt_match;

   assign rt_match = (ex_rt == id_rs) || (ex_rt == id_rt);
   assign stall    = ex_mem_read && (ex_rt != 5'd0) && rt_match && !hold && !rst;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, global hold and a saturating bubble counter.
// A bubble zeroes every field so the slot is an inert NOP with all control deasserted.
module id_ex_reg
   import pipe_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             id_instr,
   input  logic [31:0]             id_pc4,
   input  logic [31:0]             id_rd1,
   input  logic [31:0]             id_rd2,
   input  logic [31:0]             id_imm,
   input  logic [CTRL_W-1:0]       id_ctrl,
   input  logic                    hold,
   input  logic                    flush,
   output logic [31:0]             ex_instr,
   output logic [31:0]             ex_pc4,
   output logic [31:0]             ex_rd1,
   output logic [31:0]             ex_rd2,
   output logic [31:0]             ex_imm,
   output logic [CTRL_W-1:0]       ex_ctrl,
   output logic [4:0]              ex_rs,
   output logic [4:0]              ex_rt,
   output logic [4:0]              ex_rd,
   output logic                    stall,
   output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

   logic insert_bubble;

   hazard_detect u_hazard_detect (
      .ex_mem_read (ctrl_mem_read(ex_ctrl)),
      .ex_rt       (ex_rt),
      .id_rs       (id_instr[25:21]),
      .id_rt       (id_instr[20:16]),
      .hold        (hold),
      .rst         (rst),
      .stall       (stall)
   );

   // A simultaneous flush and stall still produces a single bubble.
   assign insert_bubble = flush || stall;

   // Priority: reset, then hold (freezes everything, counter included), then bubble, then normal load.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_instr   <= NOP_INSTR;
         ex_pc4     <= '0;
         ex_rd1     <= '0;
         ex_rd2     <= '0;
         ex_imm     <= '0;
         ex_ctrl    <= CTRL_NOP;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         bubble_cnt <= '0;
      end else if (hold) begin
         ex_instr   <= ex_instr;
         ex_pc4     <= ex_pc4;
         ex_rd1     <= ex_rd1;
         ex_rd2     <= ex_rd2;
         ex_imm     <= ex_imm;
         ex_ctrl    <= ex_ctrl;
         ex_rs      <= ex_rs;
         ex_rt      <= ex_rt;
         ex_rd      <= ex_rd;
         bubble_cnt <= bubble_cnt;
      end else if (insert_bubble) begin
         ex_instr <= NOP_INSTR;
         ex_pc4   <= '0;
         ex_rd1   <= '0;
         ex_rd2   <= '0;
         ex_imm   <= '0;
         ex_ctrl  <= CTRL_NOP;
         ex_rs    <= '0;
         ex_rt    <= '0;
         ex_rd    <= '0;
         if (bubble_cnt != {BUBBLE_CNT_W{1'b1}}) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end else begin
         ex_instr <= id_instr;
         ex_pc4   <= id_pc4;
         ex_rd1   <= id_rd1;
         ex_rd2   <= id_rd2;
         ex_imm   <= id_imm;
         ex_ctrl  <= id_ctrl;
         ex_rs    <= id_instr[25:21];
         ex_rt    <= id_instr[20:16];
         ex_rd    <= id_instr[15:11];
      end
   end

endmodule
